// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline: memory access sizes and memory-stage FSM states,
// plus the alignment rule used by the memory stage.
package pipeline_pkg;
    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // Size 2'b11 is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            MEM_B:   return 1'b0;
            MEM_H:   return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction
endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store byte enables and lane replication, load lane extraction
// with sign/zero extension. Purely combinational.
module mem_lane_fmt
    import pipeline_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_store_lanes,
    output logic [31:0] o_load_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_load_word[7:0];
            2'd1:    w_byte = i_load_word[15:8];
            2'd2:    w_byte = i_load_word[23:16];
            default: w_byte = i_load_word[31:24];
        endcase
    end

    assign w_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];

    always_comb begin
        o_be          = 4'b1111;
        o_store_lanes = i_store_data;
        o_load_data   = i_load_word;
        case (i_size)
            MEM_B: begin
                o_be          = 4'b0001 << i_addr_lo;
                o_store_lanes = {4{i_store_data[7:0]}};
                o_load_data   = {{24{i_signed & w_byte[7]}}, w_byte};
            end
            MEM_H: begin
                o_be          = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_store_lanes = {2{i_store_data[15:0]}};
                o_load_data   = {{16{i_signed & w_half[15]}}, w_half};
            end
            MEM_W, 2'b11: begin
                o_be          = 4'b1111;
                o_store_lanes = i_store_data;
                o_load_data   = i_load_word;
            end
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one data-memory request per aligned load/store, stalls the
// upstream pipeline until ack or timeout, and formats load data for MEM/WB.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT       = 255,
    parameter logic [31:0] RESET_PC_DATA = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignedM,
    input  logic [31:0] AluOutM,
    input  logic [31:0] WriteDataM,
    input  logic        RegWriteM,
    output logic        StallM,
    output logic        RegWriteValidM,
    output logic [31:0] MemOut,
    output logic        AlignErrM,
    output logic        BusErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [1:0]  o_dbg_state
);
    // Handshake: dmem_req is held high for the whole BUSY state; the memory completes the
    // request by raising dmem_ack (with dmem_rdata for loads) in any cycle where req is
    // high, and req drops at the following edge. Acks seen outside BUSY are ignored.
    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    mem_state_e  r_state;
    mem_state_e  w_next;
    logic [7:0]  r_cnt;
    logic        r_is_load;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_addr_lo;
    logic        r_bus_err;

    logic        w_access;
    logic        w_misaligned;
    logic        w_timeout;
    logic [1:0]  w_fmt_size;
    logic        w_fmt_signed;
    logic [1:0]  w_fmt_addr_lo;
    logic [3:0]  w_be;
    logic [31:0] w_store_lanes;
    logic [31:0] w_load_data;

    assign w_access     = MemReadM | MemWriteM;
    assign w_misaligned = is_misaligned(MemSizeM, AluOutM[1:0]);
    assign w_timeout    = (r_cnt == LP_TIMEOUT);

    // Store formatting needs the live inputs in IDLE; load formatting needs the captured ones in BUSY.
    assign w_fmt_size    = (r_state == IDLE) ? MemSizeM     : r_size;
    assign w_fmt_signed  = (r_state == IDLE) ? MemSignedM   : r_signed;
    assign w_fmt_addr_lo = (r_state == IDLE) ? AluOutM[1:0] : r_addr_lo;

    mem_lane_fmt u_lane_fmt (
        .i_size        (w_fmt_size),
        .i_signed      (w_fmt_signed),
        .i_addr_lo     (w_fmt_addr_lo),
        .i_store_data  (WriteDataM),
        .i_load_word   (dmem_rdata),
        .o_be          (w_be),
        .o_store_lanes (w_store_lanes),
        .o_load_data   (w_load_data)
    );

    always_comb begin
        w_next    = r_state;
        StallM    = 1'b0;
        AlignErrM = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        if (w_misaligned) begin
                            AlignErrM = 1'b1;
                        end else begin
                            StallM = 1'b1;
                            w_next = BUSY;
                        end
                    end
                end
                BUSY: begin
                    StallM = 1'b1;
                    if (dmem_ack || w_timeout) w_next = DONE;
                end
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_is_load  <= 1'b0;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_addr_lo  <= 2'b00;
            r_bus_err  <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'h0;
            dmem_wdata <= 32'h0;
            MemOut     <= RESET_PC_DATA;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_next == BUSY) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWriteM;
                        dmem_addr  <= {AluOutM[31:2], 2'b00};
                        dmem_be    <= w_be;
                        dmem_wdata <= w_store_lanes;
                        r_is_load  <= ~MemWriteM;
                        r_size     <= MemSizeM;
                        r_signed   <= MemSignedM;
                        r_addr_lo  <= AluOutM[1:0];
                        r_cnt      <= 8'd0;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (r_is_load) MemOut <= w_load_data;
                    end else if (w_timeout) begin
                        dmem_req  <= 1'b0;
                        MemOut    <= 32'h0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_cnt     <= 8'd0;
                    r_bus_err <= 1'b0;
                end
            endcase
        end
    end

    assign BusErrM        = r_bus_err;
    assign RegWriteValidM = RegWriteM & ~StallM & ~AlignErrM & ~BusErrM;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset-during-access sequence and
// randomized ops checked against an arithmetic reference model.
module tb_mem_stage;
  logic        clk;
  logic        rst_n;
  logic        MemReadM, MemWriteM, MemSignedM, RegWriteM;
  logic [1:0]  MemSizeM;
  logic [31:0] AluOutM, WriteDataM;
  logic        StallM, RegWriteValidM, AlignErrM, BusErrM;
  logic [31:0] MemOut;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int failures = 0;
  int cur_op = 0;
  logic [31:0] mem_model;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [1:0]  size;
    bit          sgn;
    bit          rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    bit          exp_align;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_memout;
    int          exp_stall;
    bit          exp_buserr;
  } vec_t;

  mem_stage #(.TIMEOUT(4), .RESET_PC_DATA(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .MemReadM       (MemReadM),
    .MemWriteM      (MemWriteM),
    .MemSizeM       (MemSizeM),
    .MemSignedM     (MemSignedM),
    .AluOutM        (AluOutM),
    .WriteDataM     (WriteDataM),
    .RegWriteM      (RegWriteM),
    .StallM         (StallM),
    .RegWriteValidM (RegWriteValidM),
    .MemOut         (MemOut),
    .AlignErrM      (AlignErrM),
    .BusErrM        (BusErrM),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack),
    .o_dbg_state    (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog op=%0d", cur_op);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s op=%0d actual=%08h required=%08h", name, cur_op, act, exp);
    end
  endtask

  task automatic drive_idle();
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    MemSizeM   = 2'b00;
    MemSignedM = 1'b0;
    AluOutM    = 32'h0;
    WriteDataM = 32'h0;
    RegWriteM  = 1'b0;
  endtask

  function automatic vec_t dv(input bit rd, input bit wr, input logic [1:0] size, input bit sgn,
                              input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int delay, input bit align,
                              input logic [3:0] be, input logic [31:0] wd, input logic [31:0] mo,
                              input int stall, input bit berr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn; v.rw = rw;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.delay = delay;
    v.exp_align = align; v.exp_be = be; v.exp_wdata = wd; v.exp_memout = mo;
    v.exp_stall = stall; v.exp_buserr = berr;
    return v;
  endfunction

  // Reference model: byte counts, offsets and masks in plain arithmetic.
  function automatic vec_t model(input bit rd, input bit wr, input logic [1:0] size, input bit sgn,
                                 input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int delay, input logic [31:0] prev);
    vec_t   v;
    int     nb;
    int     off;
    longint val;
    v = dv(rd, wr, size, sgn, rw, addr, wdata, rdata, delay, 0, 0, 0, prev, 0, 0);
    nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    off = int'(addr % 32'd4);
    v.exp_align = (rd || wr) && ((off % nb) != 0);
    v.exp_be    = 4'(((1 << nb) - 1) << off);
    if (nb == 1)      v.exp_wdata = 32'(wdata[7:0])  * 32'h01010101;
    else if (nb == 2) v.exp_wdata = 32'(wdata[15:0]) * 32'h00010001;
    else              v.exp_wdata = wdata;
    val = (longint'(rdata) >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
    if (sgn && (((val >> (8 * nb - 1)) & 1) == 1)) val = val - (longint'(1) << (8 * nb));
    if (rd && !wr && !v.exp_align) v.exp_memout = 32'(val);
    v.exp_stall = ((rd || wr) && !v.exp_align) ? delay + 2 : 0;
    return v;
  endfunction

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after the op retires.
  task automatic run_op(input vec_t v);
    int stall_n;
    bit done;
    bit acc;
    acc        = v.rd | v.wr;
    MemReadM   = v.rd;
    MemWriteM  = v.wr;
    MemSizeM   = v.size;
    MemSignedM = v.sgn;
    AluOutM    = v.addr;
    WriteDataM = v.wdata;
    RegWriteM  = v.rw;
    dmem_ack   = 1'b0;
    stall_n    = 0;
    done       = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        dmem_ack   = ((c - 1) == v.delay);
        dmem_rdata = ((c - 1) == v.delay) ? v.rdata : $urandom;
      end
      #4;
      if (c == 0) begin
        chk("req_in_idle", dmem_req, 1'b0);
        chk("align_err", AlignErrM, v.exp_align);
        if (!acc || v.exp_align) begin
          chk("stall_no_req", StallM, 1'b0);
          chk("rwvalid_idle", RegWriteValidM, v.rw & !v.exp_align);
          chk("memout_kept", MemOut, v.exp_memout);
          done = 1'b1;
        end
      end
      if (!done) begin
        if (StallM) begin
          stall_n++;
          if (c >= 1) chk("req_busy", dmem_req, 1'b1);
          else chk("rwvalid_stall", RegWriteValidM, 1'b0);
          if (c == 1) begin
            chk("dmem_addr", dmem_addr, v.addr & 32'hFFFF_FFFC);
            chk("dmem_we", dmem_we, v.wr);
            chk("dmem_be", dmem_be, v.exp_be);
            if (v.wr) chk("dmem_wdata", dmem_wdata, v.exp_wdata);
          end
        end else begin
          chk("done_memout", MemOut, v.exp_memout);
          chk("done_buserr", BusErrM, v.exp_buserr);
          chk("done_rwvalid", RegWriteValidM, v.rw & !v.exp_buserr);
          chk("done_req_low", dmem_req, 1'b0);
          chk("stall_cycles", stall_n, v.exp_stall);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("op_cycle_budget", 32'd0, 32'd1);
    dmem_ack  = 1'b0;
    mem_model = v.exp_memout;
    drive_idle();
    cur_op++;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    rst_n      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    mem_model  = 32'h0;
    drive_idle();
    #2;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_be", dmem_be, 4'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_stall", StallM, 1'b0);
    chk("rst_align", AlignErrM, 1'b0);
    chk("rst_buserr", BusErrM, 1'b0);
    chk("rst_memout", MemOut, 32'h0);
    chk("rst_state", o_dbg_state, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed vectors (bench TIMEOUT = 4)
    tbl.push_back(dv(1,0,2'b10,0,1,32'h100,32'h0,32'hDEADBEEF,0, 0,4'hF,32'h0,32'hDEADBEEF,2,0));
    tbl.push_back(dv(1,0,2'b00,1,1,32'h103,32'h0,32'h80112233,0, 0,4'b1000,32'h0,32'hFFFFFF80,2,0));
    tbl.push_back(dv(1,0,2'b00,0,1,32'h103,32'h0,32'h80112233,0, 0,4'b1000,32'h0,32'h00000080,2,0));
    tbl.push_back(dv(0,1,2'b01,0,0,32'h202,32'h0000ABCD,32'h0,0, 0,4'b1100,32'hABCDABCD,32'h00000080,2,0));
    tbl.push_back(dv(1,0,2'b10,0,1,32'h101,32'h0,32'h0,0, 1,4'h0,32'h0,32'h00000080,0,0));
    tbl.push_back(dv(1,0,2'b10,0,1,32'h300,32'h0,32'h11223344,0, 0,4'hF,32'h0,32'h11223344,2,0));
    tbl.push_back(dv(0,1,2'b00,0,0,32'h305,32'h0000005A,32'h0,3, 0,4'b0010,32'h5A5A5A5A,32'h11223344,5,0));
    tbl.push_back(dv(1,0,2'b01,1,1,32'h306,32'h0,32'h80017FFF,1, 0,4'b1100,32'h0,32'hFFFF8001,3,0));
    tbl.push_back(dv(1,0,2'b10,0,1,32'h400,32'h0,32'h0,-1, 0,4'hF,32'h0,32'h0,6,1));
    tbl.push_back(dv(0,1,2'b01,0,0,32'h203,32'h1234,32'h0,0, 1,4'h0,32'h0,32'h0,0,0));
    tbl.push_back(dv(1,1,2'b10,0,0,32'h500,32'h12345678,32'hFFFFFFFF,0, 0,4'hF,32'h12345678,32'h0,2,0));
    tbl.push_back(dv(1,0,2'b11,0,1,32'h504,32'h0,32'hCAFEF00D,2, 0,4'hF,32'h0,32'hCAFEF00D,4,0));
    tbl.push_back(dv(0,0,2'b00,0,1,32'h7,32'h0,32'h0,0, 0,4'h0,32'h0,32'hCAFEF00D,0,0));
    foreach (tbl[i]) run_op(tbl[i]);

    // reset asserted in the second BUSY cycle, then a late ack
    MemReadM  = 1'b1;
    MemSizeM  = 2'b10;
    AluOutM   = 32'h600;
    RegWriteM = 1'b1;
    dmem_ack  = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid_req_before_rst", dmem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", dmem_req, 1'b0);
    chk("mid_rst_state", o_dbg_state, 2'd0);
    chk("mid_rst_memout", MemOut, 32'h0);
    chk("mid_rst_stall", StallM, 1'b0);
    drive_idle();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h55AA55AA;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("late_ack_state", o_dbg_state, 2'd0);
    chk("late_ack_req", dmem_req, 1'b0);
    chk("late_ack_memout", MemOut, 32'h0);
    dmem_ack  = 1'b0;
    mem_model = 32'h0;
    cur_op++;

    // randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      v = model(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom, $urandom_range(0, 3), mem_model);
      run_op(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Performs loads and stores against the data memory over a req/ack handshake, with byte, half and word sizes.
- Formats load data into MemOut for MEM/WB, stalls the upstream pipeline while an access is outstanding, and flags misaligned or timed-out accesses.

Parameters:
- TIMEOUT, 255: maximum BUSY cycles waiting for dmem_ack before abort; 8-bit counter.
- RESET_PC_DATA, 32'h0: reset value of MemOut.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage
- MemSizeM  in  2  00 byte, 01 half, 10 word (11 treated as word)
- MemSignedM  in  1  1 = sign-extend load, 0 = zero-extend
- AluOutM  in  32  effective byte address
- WriteDataM  in  32  store data, right-aligned
- RegWriteM  in  1  writeback enable from EX/MEM
- StallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- RegWriteValidM  out  1  RegWriteM & ~StallM & ~AlignErrM & ~BusErrM; feeds MEM/WB RegWriteM
- MemOut  out  32  formatted load data, valid in the DONE cycle
- AlignErrM  out  1  one-cycle misalignment flag
- BusErrM  out  1  one-cycle timeout flag
- dmem_req  out  1  access request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  32  {AluOutM[31:2],2'b00}, registered
- dmem_be  out  4  byte enables, registered
- dmem_wdata  out  32  lane-replicated store data, registered
- dmem_rdata  in  32  read word, valid with dmem_ack
- dmem_ack  in  1  completes the request in the same cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE. dmem_req, dmem_we, dmem_be, StallM, AlignErrM, BusErrM = 0. dmem_addr, dmem_wdata = 0. MemOut = RESET_PC_DATA. Timeout counter = 0.
- A reset asserted mid-access drops dmem_req immediately. A late ack after reset is ignored.
- Access = MemReadM | MemWriteM.
- Misaligned = (half & AluOutM[0]) | (word & AluOutM[1:0]!=0).
- FSM IDLE:
  - No access: StallM=0, pass-through.
  - Misaligned access: no request issued. AlignErrM=1 and StallM=0 that cycle; the instruction advances with RegWriteValidM=0. Stay IDLE.
  - Aligned access: StallM=1 (combinational). Register addr, we, be, wdata. Go to BUSY.
- FSM BUSY:
  - dmem_req=1 and StallM=1; counter increments each cycle.
  - dmem_ack=1: load captures formatted dmem_rdata into MemOut; store leaves MemOut unchanged. dmem_req drops next edge. Go to DONE.
  - counter==TIMEOUT with no ack: drop req, MemOut=0, BusErrM=1 in DONE. Go to DONE.
- FSM DONE:
  - StallM=0; the instruction advances into MEM/WB at this edge. Counter clears. Go to IDLE.
  - The following instruction is evaluated in IDLE the next cycle.
- Minimum latency: ack in first BUSY cycle gives 3 cycles per memory op (IDLE, BUSY, DONE), i.e. 2 stall cycles.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- wdata: byte replicated ×4, half replicated ×2, word as-is.
- Load format: select lane by addr[1:0] (byte) or addr[1] (half), then sign- or zero-extend to 32 bits.
- Simultaneous MemReadM & MemWriteM: treated as a store.
- dmem_ack outside BUSY is ignored.

Decomposition:
- Shared package (pipeline_pkg):
  - MemSize encodings (MEM_B, MEM_H, MEM_W)
  - FSM state encoding (IDLE/BUSY/DONE, 2 bits)
- One combinational sub-module, mem_lane_fmt: store lane/be generation and load extract/extend. Reused by the I-side if needed.

Test Plan:
- Word load, AluOutM=0x100, ack 1st BUSY cycle, rdata=0xDEADBEEF -> dmem_addr=0x100, be=4'b1111; StallM high 2 cycles; DONE cycle MemOut=0xDEADBEEF, RegWriteValidM=1.
- Signed byte load, addr=0x103, rdata=0x80112233 -> be=4'b1000; MemOut=0xFFFFFF80. Same with MemSignedM=0 -> MemOut=0x00000080.
- Half store, addr=0x202, WriteDataM=0x0000ABCD -> dmem_we=1, be=4'b1100, wdata=0xABCDABCD; MemOut unchanged.
- Word load, addr=0x101 -> no dmem_req; AlignErrM=1 for 1 cycle, StallM=0, RegWriteValidM=0.
- Ack withheld, TIMEOUT=4 -> req high 5 BUSY cycles then low; BusErrM=1 and MemOut=0 in DONE. Also: rst_n low in 2nd BUSY cycle -> req=0 immediately, state IDLE, MemOut=0.
- Back-to-back load, store, load with ack delays 0/3/1 -> correct be/wdata/MemOut per op; StallM pattern 2/5/3 cycles; no request overlap.
